// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a REQ/READY handshake and
// feeds the IF/ID register with the fetched word and its PC+4.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INS  = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        STALL,
   input  logic        BRANCH_TAKEN,
   input  logic [31:0] BRANCH_TARGET,
   output logic        IMEM_REQ,
   output logic [31:0] IMEM_ADR,
   input  logic [31:0] IMEM_RDATA,
   input  logic        IMEM_READY,
   output logic [31:0] NEXT_INS_ADR_OUT,
   output logic [31:0] CUR_INS_OUT,
   output logic        INS_VALID
);

   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {
      ISSUE   = 2'd0,
      SKID    = 2'd1,
      DISCARD = 2'd2
   } state_t;

   state_t            state, state_d;
   logic [XLEN-1:0]   pc, pc_d;
   logic [XLEN-1:0]   redir, redir_d;
   logic [XLEN-1:0]   skid_pc4, skid_pc4_d;
   logic [XLEN-1:0]   skid_ins, skid_ins_d;
   logic [XLEN-1:0]   nxt_adr_d, cur_ins_d;
   logic              valid_d;
   logic [XLEN-1:0]   pc_inc;
   logic [XLEN-1:0]   target;

   // Request is suppressed while parked and while held in reset.
   assign IMEM_REQ = (state != SKID) && !RST;
   assign IMEM_ADR = pc;
   assign pc_inc   = pc + XLEN'(4);
   assign target   = {BRANCH_TARGET[XLEN-1:2], 2'b00};

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state            <= ISSUE;
         pc               <= RESET_PC;
         redir            <= RESET_PC;
         skid_pc4         <= '0;
         skid_ins         <= NOP_INS;
         NEXT_INS_ADR_OUT <= '0;
         CUR_INS_OUT      <= NOP_INS;
         INS_VALID        <= 1'b0;
      end else begin
         state            <= state_d;
         pc               <= pc_d;
         redir            <= redir_d;
         skid_pc4         <= skid_pc4_d;
         skid_ins         <= skid_ins_d;
         NEXT_INS_ADR_OUT <= nxt_adr_d;
         CUR_INS_OUT      <= cur_ins_d;
         INS_VALID        <= valid_d;
      end
   end

   always_comb begin
      state_d    = state;
      pc_d       = pc;
      redir_d    = redir;
      skid_pc4_d = skid_pc4;
      skid_ins_d = skid_ins;
      nxt_adr_d  = NEXT_INS_ADR_OUT;
      cur_ins_d  = CUR_INS_OUT;
      valid_d    = INS_VALID;

      if (BRANCH_TAKEN) begin
         // Redirect flushes the outputs; an outstanding request must finish at its old address.
         valid_d   = 1'b0;
         cur_ins_d = NOP_INS;
         unique case (state)
            ISSUE: begin
               if (IMEM_READY) begin
                  pc_d = target;
               end else begin
                  redir_d = target;
                  state_d = DISCARD;
               end
            end
            SKID: begin
               pc_d    = target;
               state_d = ISSUE;
            end
            DISCARD: begin
               redir_d = target;
               if (IMEM_READY) begin
                  pc_d    = target;
                  state_d = ISSUE;
               end
            end
            default: state_d = ISSUE;
         endcase
      end else begin
         if (!STALL) begin
            valid_d   = 1'b0;
            cur_ins_d = NOP_INS;
         end
         unique case (state)
            ISSUE: begin
               if (IMEM_READY) begin
                  pc_d = pc_inc;
                  if (STALL) begin
                     skid_pc4_d = pc_inc;
                     skid_ins_d = IMEM_RDATA;
                     state_d    = SKID;
                  end else begin
                     nxt_adr_d = pc_inc;
                     cur_ins_d = IMEM_RDATA;
                     valid_d   = 1'b1;
                  end
               end
            end
            SKID: begin
               if (!STALL) begin
                  nxt_adr_d = skid_pc4;
                  cur_ins_d = skid_ins;
                  valid_d   = 1'b1;
                  state_d   = ISSUE;
               end
            end
            DISCARD: begin
               if (IMEM_READY) begin
                  pc_d    = redir;
                  state_d = ISSUE;
               end
            end
            default: state_d = ISSUE;
         endcase
      end
   end

endmodule
